// File: rtl/gsu_membus.sv
// GSU-side initiator for the Game Pak ROM/RAM buses: arbitrates core/cache
// requests, drives strobes for a programmable number of wait cycles, and acks.
//
// state  | meaning
// IDLE   | no access; accepts RAM (priority) or ROM request when granted
// ROM_RD | ROM chip enable asserted, wait counter running
// RAM_RD | RAM output enable asserted, wait counter running
// RAM_WR | RAM write enable and data drive asserted, wait counter running
// DONE   | strobes released, ack pulsed, write data still driven
module gsu_membus #(
    parameter int unsigned ROM_WAIT = 5,
    parameter int unsigned RAM_WAIT = 5
) (
    input  logic        clkin,
    input  logic        RESET,
    input  logic        ron,
    input  logic        ran,
    input  logic        rom_req,
    input  logic [20:0] rom_a,
    output logic        rom_ack,
    output logic [7:0]  rom_rdata,
    input  logic        ram_req,
    input  logic        ram_we,
    input  logic [16:0] ram_a,
    input  logic [7:0]  ram_wdata,
    output logic        ram_ack,
    output logic [7:0]  ram_rdata,
    output logic        busy,
    output logic [20:0] bus_rom_addr,
    output logic        bus_rom_ce_n,
    input  logic [7:0]  bus_rom_data,
    output logic [16:0] bus_ram_addr,
    output logic        bus_ram_oe_n,
    output logic        bus_ram_we_n,
    output logic [7:0]  bus_ram_dout,
    output logic        bus_ram_dout_en,
    input  logic [7:0]  bus_ram_din
);

    typedef enum logic [2:0] {IDLE, ROM_RD, RAM_RD, RAM_WR, DONE} state_t;

    localparam logic [3:0] ROM_LOAD = 4'(ROM_WAIT - 1);
    localparam logic [3:0] RAM_LOAD = 4'(RAM_WAIT - 1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        rom_ack_nx, ram_ack_nx, busy_nx;
    logic [7:0]  rom_rdata_nx, ram_rdata_nx, dout_nx;
    logic [20:0] rom_addr_nx;
    logic [16:0] ram_addr_nx;
    logic        ce_n_nx, oe_n_nx, we_n_nx, dout_en_nx;

    always_ff @(posedge clkin) begin
        if (RESET) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            busy            <= 1'b0;
            rom_ack         <= 1'b0;
            ram_ack         <= 1'b0;
            rom_rdata       <= 8'h00;
            ram_rdata       <= 8'h00;
            bus_rom_addr    <= 21'd0;
            bus_ram_addr    <= 17'd0;
            bus_ram_dout    <= 8'h00;
            bus_rom_ce_n    <= 1'b1;
            bus_ram_oe_n    <= 1'b1;
            bus_ram_we_n    <= 1'b1;
            bus_ram_dout_en <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            busy            <= busy_nx;
            rom_ack         <= rom_ack_nx;
            ram_ack         <= ram_ack_nx;
            rom_rdata       <= rom_rdata_nx;
            ram_rdata       <= ram_rdata_nx;
            bus_rom_addr    <= rom_addr_nx;
            bus_ram_addr    <= ram_addr_nx;
            bus_ram_dout    <= dout_nx;
            bus_rom_ce_n    <= ce_n_nx;
            bus_ram_oe_n    <= oe_n_nx;
            bus_ram_we_n    <= we_n_nx;
            bus_ram_dout_en <= dout_en_nx;
        end
    end

    // Every output is computed here for the coming cycle and registered above.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rom_ack_nx   = 1'b0;
        ram_ack_nx   = 1'b0;
        rom_rdata_nx = rom_rdata;
        ram_rdata_nx = ram_rdata;
        rom_addr_nx  = bus_rom_addr;
        ram_addr_nx  = bus_ram_addr;
        dout_nx      = bus_ram_dout;
        ce_n_nx      = 1'b1;
        oe_n_nx      = 1'b1;
        we_n_nx      = 1'b1;
        dout_en_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (ram_req && ran) begin
                    ram_addr_nx = ram_a;
                    cnt_nx      = RAM_LOAD;
                    if (ram_we) begin
                        state_nx   = RAM_WR;
                        dout_nx    = ram_wdata;
                        we_n_nx    = 1'b0;
                        dout_en_nx = 1'b1;
                    end else begin
                        state_nx = RAM_RD;
                        oe_n_nx  = 1'b0;
                    end
                end else if (rom_req && ron) begin
                    state_nx    = ROM_RD;
                    rom_addr_nx = rom_a;
                    cnt_nx      = ROM_LOAD;
                    ce_n_nx     = 1'b0;
                end
            end
            ROM_RD: begin
                if (!ron) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx     = DONE;
                    rom_rdata_nx = bus_rom_data;
                    rom_ack_nx   = 1'b1;
                end else begin
                    cnt_nx  = cnt - 4'd1;
                    ce_n_nx = 1'b0;
                end
            end
            RAM_RD: begin
                if (!ran) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx     = DONE;
                    ram_rdata_nx = bus_ram_din;
                    ram_ack_nx   = 1'b1;
                end else begin
                    cnt_nx  = cnt - 4'd1;
                    oe_n_nx = 1'b0;
                end
            end
            RAM_WR: begin
                // Data drive stays on through DONE to give the SRAM hold time.
                if (!ran) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx   = DONE;
                    ram_ack_nx = 1'b1;
                    dout_en_nx = 1'b1;
                end else begin
                    cnt_nx     = cnt - 4'd1;
                    we_n_nx    = 1'b0;
                    dout_en_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule
